// File: rtl/delay_chain_pkg.sv
// Shared types and helpers for the runtime-programmable delay line.
package delay_chain_pkg;

  typedef enum logic {FILL, RUN} dc_state_t;

  function automatic int unsigned clamp_len(input int unsigned value, input int unsigned max_len);
    return (value > max_len) ? max_len : value;
  endfunction

endpackage

// File: rtl/delay_tap_chain.sv
// MAX_LEN-deep shift register with enable and synchronous clear; every tap is exposed.
module delay_tap_chain #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] taps [MAX_LEN]
);

  logic [DW-1:0] tap_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        tap_q[k] <= '0;
      end
    end else if (en) begin
      tap_q[0] <= in;
      for (int k = 1; k < MAX_LEN; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  assign taps = tap_q;

endmodule

// File: rtl/delay_chain_ctrl.sv
// Delay line controller: runtime delay selection, fill tracking and output masking.
module delay_chain_ctrl
  import delay_chain_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned DEF_LEN = 4,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in,
  input  logic [LW-1:0] dly_set,
  input  logic          dly_load,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic [LW-1:0] dly_cur,
  output logic          busy,
  output logic          cfg_err
);

  localparam logic [LW-1:0] MaxLenL  = LW'(MAX_LEN);
  localparam logic [LW-1:0] DefLenL  = LW'(DEF_LEN);
  localparam dc_state_t     RstState = (DEF_LEN == 0) ? RUN : FILL;

  logic [DW-1:0] taps [MAX_LEN];

  delay_tap_chain #(
    .DW     (DW),
    .MAX_LEN(MAX_LEN)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (in),
    .taps(taps)
  );

  dc_state_t     state_q, state_d;
  logic [LW-1:0] fill_cnt_q, fill_cnt_d;
  logic [LW-1:0] dly_cur_q, dly_cur_d;
  logic          cfg_err_q, cfg_err_d;
  logic [LW-1:0] fill_inc;

  assign fill_inc = fill_cnt_q + LW'(1);

  // A load wins over fill progress; the sample shifted alongside a load is not counted.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    dly_cur_d  = dly_cur_q;
    cfg_err_d  = 1'b0;
    if (dly_load) begin
      dly_cur_d  = LW'(clamp_len(32'(dly_set), MAX_LEN));
      cfg_err_d  = (dly_set > MaxLenL);
      fill_cnt_d = '0;
      state_d    = (dly_cur_d == '0) ? RUN : FILL;
    end else if (state_q == FILL && en) begin
      if (fill_inc == dly_cur_q) begin
        state_d    = RUN;
        fill_cnt_d = '0;
      end else begin
        fill_cnt_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RstState;
      fill_cnt_q <= '0;
      dly_cur_q  <= DefLenL;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      dly_cur_q  <= dly_cur_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Zero delay bypasses the chain entirely.
  always_comb begin
    out = in;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (dly_cur_q == LW'(k + 1)) begin
        out = taps[k];
      end
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == FILL);
  assign dly_cur   = dly_cur_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Directed bench for delay_chain_ctrl with a sample-history reference model.
module tb_delay_chain_ctrl;

  localparam int DW      = 8;
  localparam int MAX_LEN = 16;
  localparam int DEF_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] in = '0;
  logic [LW-1:0] dly_set = '0;
  logic          dly_load = 1'b0;
  logic [DW-1:0] out;
  logic          out_valid;
  logic [LW-1:0] dly_cur;
  logic          busy;
  logic          cfg_err;

  int n_cmp = 0;
  int n_mis = 0;

  delay_chain_ctrl #(
    .DW     (DW),
    .MAX_LEN(MAX_LEN),
    .DEF_LEN(DEF_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .dly_set  (dly_set),
    .dly_load (dly_load),
    .out      (out),
    .out_valid(out_valid),
    .dly_cur  (dly_cur),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of enabled samples (reset fills it with zeros),
  // plus count of enabled samples accepted since the delay was last set.
  logic [DW-1:0] hist[$];
  int            m_dly;
  int            m_cnt;
  bit            m_err;
  bit            m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int k = 0; k < MAX_LEN; k++) hist.push_back('0);
      m_dly = DEF_LEN;
      m_cnt = 0;
      m_err = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      if (en) begin
        hist.push_back(in);
        void'(hist.pop_front());
      end
      if (dly_load) begin
        m_dly = (int'(dly_set) > MAX_LEN) ? MAX_LEN : int'(dly_set);
        m_err = (int'(dly_set) > MAX_LEN);
        m_cnt = 0;
      end else begin
        m_err = 1'b0;
        if (en && m_cnt < MAX_LEN) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      automatic bit vld = (m_dly == 0) || (m_cnt >= m_dly);
      check("model_dly_cur", int'(dly_cur), m_dly);
      check("model_out_valid", int'(out_valid), int'(vld));
      check("model_busy", int'(busy), int'(!vld));
      check("model_cfg_err", int'(cfg_err), int'(m_err));
      if (vld) begin
        check("model_out", int'(out), (m_dly == 0) ? int'(in) : int'(hist[MAX_LEN - m_dly]));
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [DW-1:0] d,
                     input logic l, input logic [LW-1:0] s);
    rst      = r;
    en       = e;
    in       = d;
    dly_load = l;
    dly_set  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with DEF_LEN=4
    cyc(1, 0, 0, 0, 0);
    check("rst_dly_cur", int'(dly_cur), 4);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cfg_err", int'(cfg_err), 0);

    // Fill with 1,2,3,...
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, DW'(i), 0, 0);
      if (i == 3) check("fill3_valid", int'(out_valid), 0);
      if (i == 4) begin
        check("fill4_valid", int'(out_valid), 1);
        check("fill4_out", int'(out), 1);
      end
    end
    check("run_out_lag4", int'(out), 5);

    // Zero delay: bypass
    cyc(0, 1, 13, 1, 0);
    check("zero_dly_cur", int'(dly_cur), 0);
    check("zero_valid", int'(out_valid), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_out_eq_in", int'(out), 13);

    // Over-range load clamps to MAX_LEN
    cyc(0, 1, 14, 1, 20);
    check("clamp_dly_cur", int'(dly_cur), 16);
    check("clamp_cfg_err", int'(cfg_err), 1);
    check("clamp_busy", int'(busy), 1);
    for (int i = 15; i <= 30; i++) begin
      cyc(0, 1, DW'(i), 0, 0);
      if (i == 15) check("clamp_err_pulse", int'(cfg_err), 0);
      if (i == 29) check("clamp_valid_early", int'(out_valid), 0);
    end
    check("clamp_valid", int'(out_valid), 1);
    check("clamp_out", int'(out), 15);

    // Gapped enable during FILL with delay 3
    cyc(0, 0, 40, 1, 3);
    cyc(0, 1, 41, 0, 0);
    cyc(0, 0, 42, 0, 0);
    cyc(0, 1, 43, 0, 0);
    check("gap_valid_2", int'(out_valid), 0);
    cyc(0, 0, 44, 0, 0);
    check("gap_valid_hold", int'(out_valid), 0);
    cyc(0, 1, 45, 0, 0);
    check("gap_valid_3", int'(out_valid), 1);
    check("gap_out", int'(out), 41);
    cyc(0, 0, 46, 0, 0);
    check("gap_out_hold", int'(out), 41);

    // Load together with en: that sample is not counted
    cyc(0, 1, 50, 1, 2);
    cyc(0, 1, 51, 0, 0);
    check("ld_en_valid1", int'(out_valid), 0);
    cyc(0, 1, 52, 0, 0);
    check("ld_en_valid2", int'(out_valid), 1);
    check("ld_en_out", int'(out), 51);

    // Reset mid-FILL with simultaneous load
    cyc(0, 1, 60, 1, 5);
    cyc(0, 1, 61, 0, 0);
    cyc(1, 1, 62, 1, 9);
    check("rstfill_dly_cur", int'(dly_cur), 4);
    check("rstfill_busy", int'(busy), 1);
    check("rstfill_cfg_err", int'(cfg_err), 0);
    for (int i = 70; i <= 74; i++) cyc(0, 1, DW'(i), 0, 0);
    check("rstfill_out", int'(out), 71);

    // Reset mid-RUN with simultaneous over-range load
    cyc(1, 1, 80, 1, 20);
    check("rstrun_dly_cur", int'(dly_cur), 4);
    check("rstrun_busy", int'(busy), 1);
    check("rstrun_cfg_err", int'(cfg_err), 0);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++) begin
      cyc(0, logic'(i % 3 != 0), DW'(100 + i), logic'(i % 17 == 5), LW'(i % 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
